ysyx_23060025_ifu: RTL

Instruction fetch unit sitting directly upstream of the instruction cache and directly upstream of the decode stage (IDU). It owns the PC, issues one fetch at a time to the icache over the psel/pready handshake, and holds the returned instruction in a one-entry output buffer until IDU accepts it. It also squashes wrong-path fetches on redirect and sequences fence.i invalidation into the icache.

---
 rtl/ysyx_23060025_ifu_pkg.sv | 14 +
 rtl/ysyx_23060025_ifu_if.sv | 30 +++
 rtl/ysyx_23060025_pipe_reg.sv | 35 +++
 rtl/ysyx_23060025_ifu.sv | 103 ++++++++++
 4 files changed

// File: rtl/ysyx_23060025_ifu_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
package ysyx_23060025_ifu_pkg;

  localparam int unsigned IFU_ADDR_WIDTH = 32;
  localparam int unsigned IFU_INST_WIDTH = 32;
  localparam logic [31:0] IFU_RESET_PC   = 32'h3000_0000;

  typedef enum logic [1:0] {
    IFU_IDLE,
    IFU_FETCH,
    IFU_FENCE
  } ifu_state_e;

endpackage

// File: rtl/ysyx_23060025_ifu_if.sv
// IFU bundle: icache fetch handshake, IDU output handshake and redirect/fence inputs.
interface ysyx_23060025_ifu_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  psel;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  fence_flag;

  logic [DATA_WIDTH-1:0] inst;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  valid;
  logic                  ready;

  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  fence_req;

  modport master (
    output paddr, psel, fence_flag, inst, pc, valid,
    input  pready, prdata, ready, redirect_valid, redirect_pc, fence_req
  );

  modport slave (
    input  paddr, psel, fence_flag, inst, pc, valid,
    output pready, prdata, ready, redirect_valid, redirect_pc, fence_req
  );
endinterface

// File: rtl/ysyx_23060025_pipe_reg.sv
// One-entry valid/ready holding register with flush; flush wins over enqueue and dequeue.
module ysyx_23060025_pipe_reg #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_data,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_data
);

  logic             full;
  logic [WIDTH-1:0] store;

  assign enq_ready = !full || deq_ready;
  assign deq_valid = full;
  assign deq_data  = store;

  always_ff @(posedge clock) begin
    if (reset) begin
      full  <= 1'b0;
      store <= '0;
    end else begin
      if (flush)          full <= 1'b0;
      else if (enq_valid) full <= 1'b1;
      else if (deq_ready) full <= 1'b0;
      if (enq_valid && !flush) store <= enq_data;
    end
  end

endmodule

// File: rtl/ysyx_23060025_ifu.sv
// Instruction fetch unit: owns the PC, issues one icache fetch at a time,
// buffers the result for IDU, squashes wrong-path fetches and sequences fence.i.
module ysyx_23060025_ifu
  import ysyx_23060025_ifu_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = IFU_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH = IFU_INST_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = IFU_RESET_PC
) (
  input logic                 clock,
  input logic                 reset,
  ysyx_23060025_ifu_if.master bus
);

  ifu_state_e state, state_next;

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  kill;
  logic                  fence_pending;

  logic launch;
  logic resp;
  logic resp_keep;
  logic buf_space;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] buf_data;

  assign resp      = (state == IFU_FETCH) && bus.pready;
  // A response is dropped if its fetch was killed earlier or a redirect lands on it.
  assign resp_keep = resp && !kill && !bus.redirect_valid;

  always_ff @(posedge clock) begin
    if (reset) state <= IFU_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    unique case (state)
      IFU_IDLE: begin
        if (fence_pending || bus.fence_req) begin
          state_next = IFU_FENCE;
        end else if (buf_space && !bus.redirect_valid) begin
          state_next = IFU_FETCH;
          launch     = 1'b1;
        end
      end
      IFU_FETCH: if (bus.pready) state_next = IFU_IDLE;
      IFU_FENCE: state_next = IFU_IDLE;
      default:   state_next = IFU_IDLE;
    endcase
  end

  always_comb begin
    bus.psel       = 1'b0;
    bus.fence_flag = 1'b0;
    unique case (state)
      IFU_FETCH: bus.psel       = !bus.pready;
      IFU_FENCE: bus.fence_flag = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc            <= RESET_PC;
      fetch_addr    <= '0;
      kill          <= 1'b0;
      fence_pending <= 1'b0;
    end else begin
      if (launch) fetch_addr <= pc;

      if (bus.redirect_valid) pc <= {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      else if (resp_keep)     pc <= fetch_addr + ADDR_WIDTH'(4);

      if (resp)                                           kill <= 1'b0;
      else if (state == IFU_FETCH && bus.redirect_valid)  kill <= 1'b1;

      if (bus.fence_req)             fence_pending <= 1'b1;
      else if (state == IFU_FENCE)   fence_pending <= 1'b0;
    end
  end

  assign bus.paddr = fetch_addr;

  ysyx_23060025_pipe_reg #(
    .WIDTH(ADDR_WIDTH + DATA_WIDTH)
  ) u_out_buf (
    .clock    (clock),
    .reset    (reset),
    .flush    (bus.redirect_valid),
    .enq_valid(resp_keep),
    .enq_ready(buf_space),
    .enq_data ({fetch_addr, bus.prdata}),
    .deq_valid(bus.valid),
    .deq_ready(bus.ready),
    .deq_data (buf_data)
  );

  assign {bus.pc, bus.inst} = buf_data;

endmodule
